ws2812_decoder: RTL

Single-wire WS2812B-style pulse-stream receiver: recovers 24-bit colour words from the one-bit `datastream` produced by the LED-matrix stream generator. It is the receive end of that protocol. It sits beside the face programmer for loopback checking of the LED drive, and it can also take the output of a daisy-chained matrix. It classifies each high pulse by width, assembles bits LSB-first, flags malformed pulses, and reports frame ends, which are long low periods.

---
 rtl/ws2812_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ws2812_decoder.sv
// WS2812B-style single-wire receiver: classifies high pulses by width, assembles
// 24-bit words LSB-first, and reports words, frame ends (long lows) and protocol errors.
module ws2812_decoder #(
  parameter int BIT_THRESH = 25,
  parameter int MIN_HIGH   = 8,
  parameter int MAX_HIGH   = 60,
  parameter int MAX_LOW    = 100,
  parameter int RESET_LOW  = 1000,
  parameter int SYNC_LOW   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        datastream,
  output logic [23:0] data,
  output logic        valid,
  output logic        frame_end,
  output logic        err,
  output logic [8:0]  word_count
);

  localparam logic [10:0] BIT_THRESH_W = 11'(BIT_THRESH);
  localparam logic [10:0] MIN_HIGH_W   = 11'(MIN_HIGH);
  localparam logic [10:0] MAX_HIGH_W   = 11'(MAX_HIGH);
  localparam logic [10:0] MAX_LOW_W    = 11'(MAX_LOW);
  localparam logic [10:0] RESET_LOW_W  = 11'(RESET_LOW);
  localparam logic [10:0] SYNC_LOW_W   = 11'(SYNC_LOW);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t      state, state_next;
  logic        sync_ff, s;
  logic [10:0] hcnt, hcnt_next, hcnt_inc;
  logic [10:0] lcnt, lcnt_next, lcnt_inc;
  logic [4:0]  bitcnt, bitcnt_next;
  logic [23:0] shreg, shreg_next, data_next;
  logic        valid_next, frame_end_next, err_next;
  logic [8:0]  word_count_next;

  assign hcnt_inc = (hcnt == 11'h7ff) ? hcnt : hcnt + 11'd1;
  assign lcnt_inc = (lcnt == 11'h7ff) ? lcnt : lcnt + 11'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff    <= 1'b0;
      s          <= 1'b0;
      state      <= SYNC;
      hcnt       <= '0;
      lcnt       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_end  <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      sync_ff    <= datastream;
      s          <= sync_ff;
      state      <= state_next;
      hcnt       <= hcnt_next;
      lcnt       <= lcnt_next;
      bitcnt     <= bitcnt_next;
      shreg      <= shreg_next;
      data       <= data_next;
      valid      <= valid_next;
      frame_end  <= frame_end_next;
      err        <= err_next;
      word_count <= word_count_next;
    end
  end

  // lcnt doubles as the SYNC low-run counter; the count clears the cycle after frame_end.
  always_comb begin
    state_next      = state;
    hcnt_next       = hcnt;
    lcnt_next       = lcnt;
    bitcnt_next     = bitcnt;
    shreg_next      = shreg;
    data_next       = data;
    valid_next      = 1'b0;
    frame_end_next  = 1'b0;
    err_next        = 1'b0;
    word_count_next = frame_end ? 9'd0 : word_count;

    case (state)
      SYNC: begin
        if (s) begin
          lcnt_next = '0;
        end else begin
          lcnt_next = lcnt_inc;
          if (lcnt_inc >= SYNC_LOW_W) begin
            state_next  = IDLE;
            bitcnt_next = '0;
          end
        end
      end

      IDLE: begin
        if (s) begin
          state_next = HIGH;
          hcnt_next  = 11'd1;
        end
      end

      HIGH: begin
        if (s) begin
          hcnt_next = hcnt_inc;
        end else if (hcnt < MIN_HIGH_W || hcnt > MAX_HIGH_W) begin
          err_next    = 1'b1;
          state_next  = SYNC;
          lcnt_next   = 11'd1;
          bitcnt_next = '0;
        end else begin
          shreg_next[bitcnt] = (hcnt >= BIT_THRESH_W);
          if (bitcnt == 5'd23) begin
            data_next       = shreg_next;
            valid_next      = 1'b1;
            word_count_next = (word_count == 9'h1ff) ? word_count : word_count + 9'd1;
            bitcnt_next     = '0;
          end else begin
            bitcnt_next = bitcnt + 5'd1;
          end
          state_next = LOW;
          lcnt_next  = 11'd1;
        end
      end

      LOW: begin
        if (s) begin
          if (bitcnt != 5'd0 && lcnt > MAX_LOW_W) begin
            err_next    = 1'b1;
            state_next  = SYNC;
            lcnt_next   = '0;
            bitcnt_next = '0;
          end else begin
            state_next = HIGH;
            hcnt_next  = 11'd1;
          end
        end else begin
          lcnt_next = lcnt_inc;
          if (lcnt_inc >= RESET_LOW_W) begin
            frame_end_next = 1'b1;
            err_next       = (bitcnt != 5'd0);
            bitcnt_next    = '0;
            state_next     = IDLE;
          end
        end
      end

      default: state_next = SYNC;
    endcase
  end

endmodule
